// File: rtl/mem_xfer_engine.sv
// Pairwise add/sub transfer from A (DEPTH_A words) into B (DEPTH_A/2 words); XFER takes DEPTH_A/2 cycles.
// Load port stalls (load_ready=0) outside LOAD; rd_data has 1-cycle latency and never stalls.
module mem_xfer_engine #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_A = 8,
    parameter int SAT     = 0,
    localparam int AW     = $clog2(DEPTH_A),
    localparam int BW     = (DEPTH_A > 2) ? $clog2(DEPTH_A / 2) : 1
) (
    input  logic             clock,
    input  logic             Reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    input  logic [BW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // B is sized to the full rd_addr range so every read address is backed by a register.
    localparam int BD = 1 << BW;
    localparam logic [BW-1:0] K_LAST = BW'(DEPTH_A / 2 - 1);

    typedef enum logic [1:0] {ST_LOAD, ST_FULL, ST_XFER, ST_DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mem_a [DEPTH_A];
    logic [WIDTH-1:0] mem_b [BD];
    logic [AW-1:0]    wp;
    logic [BW-1:0]    k;
    logic             mode_q;
    logic             accept;
    logic [AW-1:0]    lo_idx;
    logic [AW-1:0]    hi_idx;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] res;
    logic             flag;

    assign load_ready = Reset && (state == ST_LOAD);
    assign accept     = load_valid && load_ready;
    assign busy       = (state == ST_XFER);
    assign done       = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (accept && (wp == AW'(DEPTH_A - 1))) state_nxt = ST_FULL;
            ST_FULL: if (start) state_nxt = ST_XFER;
            ST_XFER: if (k == K_LAST) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_comb begin
        lo_idx   = AW'({k, 1'b0});
        hi_idx   = lo_idx | AW'(1);
        sum_ext  = {1'b0, mem_a[lo_idx]} + {1'b0, mem_a[hi_idx]};
        diff_ext = {1'b0, mem_a[lo_idx]} - {1'b0, mem_a[hi_idx]};
        flag     = 1'b0;
        res      = '0;
        if (mode_q) begin
            // the extra MSB of the difference is the borrow (lo < hi)
            flag = diff_ext[WIDTH];
            res  = (SAT != 0 && flag) ? '0 : diff_ext[WIDTH-1:0];
        end else begin
            flag = sum_ext[WIDTH];
            res  = (SAT != 0 && flag) ? '1 : sum_ext[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!Reset) begin
            state   <= ST_LOAD;
            wp      <= '0;
            k       <= '0;
            mode_q  <= 1'b0;
            ovf     <= 1'b0;
            rd_data <= '0;
            for (int i = 0; i < BD; i++) begin
                mem_b[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            rd_data <= mem_b[rd_addr];
            if (accept) begin
                wp <= wp + 1'b1;
            end
            case (state)
                ST_FULL: begin
                    if (start) begin
                        mode_q <= mode;
                        ovf    <= 1'b0;
                        k      <= '0;
                    end
                end
                ST_XFER: begin
                    mem_b[k] <= res;
                    ovf      <= ovf | flag;
                    k        <= k + 1'b1;
                end
                ST_DONE: wp <= '0;
                default: ;
            endcase
        end
    end

    // A keeps its contents across reset; writes are already gated off while Reset is low.
    always_ff @(posedge clock) begin
        if (accept) begin
            mem_a[wp] <= load_data;
        end
    end

endmodule
